// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: FSM encodings and default widths shared by the loader and the instruction bram.
// S_CSUM exists only when PROG_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_BEAT_W = 16;
  localparam int DEF_WORD_W = 48;
  localparam int BEATS_PER_WORD = 3;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_LEN     = 3'd1;
  localparam state_t S_PAYLOAD = 3'd2;
  localparam state_t S_WRITE   = 3'd3;
  localparam state_t S_DONE    = 3'd4;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t S_CSUM    = 3'd5;
`endif
endpackage

// File: rtl/prog_loader_beat_packer.sv
// prog_loader_beat_packer: shifts beats in MSB-first and flags the beat that completes a word.
module prog_loader_beat_packer import prog_loader_pkg::*; #(
  parameter int BEAT_W = DEF_BEAT_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_clear,
  input  logic                             i_shift,
  input  logic [BEAT_W-1:0]                i_beat,
  output logic [BEATS_PER_WORD*BEAT_W-1:0] o_word,
  output logic                             o_full
);
  logic [1:0]                          r_cnt;
  logic [(BEATS_PER_WORD-1)*BEAT_W-1:0] r_sr;
  assign o_word = {r_sr, i_beat};
  assign o_full = i_shift && r_cnt == 2'(BEATS_PER_WORD - 1);
  always_ff @(posedge clk)
    if (reset || i_clear) begin
      r_cnt <= '0;
      r_sr  <= '0;
    end else if (i_shift) begin
      r_cnt <= o_full ? '0 : r_cnt + 2'd1;
      r_sr  <= o_word[(BEATS_PER_WORD-1)*BEAT_W-1:0];
    end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: packs a length-prefixed 16-bit beat stream into 48-bit words written to bram port B.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum beat after the payload.
module prog_loader import prog_loader_pkg::*; #(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BEAT_W    = DEF_BEAT_W,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int MAX_WORDS = 1 << DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BEAT_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] addr_b,
  output logic [WORD_W-1:0] data_b,
  output logic              we_b,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t S_LAST = S_CSUM;
`else
  localparam state_t S_LAST = S_DONE;
`endif
  localparam logic [BEAT_W-1:0] MAX_L = BEAT_W'(MAX_WORDS);
  state_t            r_state, w_next;
  logic              r_in_ready, r_we, r_cpu_hold, r_done, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_data, w_word;
  logic [ADDR_W:0]   r_word_count, r_len;
  logic              w_start, w_acc, w_shift, w_full, w_last, w_len_bad, w_beat_next;
  assign w_start   = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_acc     = in_valid && r_in_ready;
  assign w_shift   = w_acc && r_state == S_PAYLOAD;
  assign w_len_bad = in_data > MAX_L;
  assign w_last    = r_word_count + (ADDR_W+1)'(1) == r_len;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [BEAT_W-1:0] r_csum;
  assign w_beat_next = w_next == S_LEN || w_next == S_PAYLOAD || w_next == S_CSUM;
  always_ff @(posedge clk)
    if (reset || w_start) r_csum <= '0;
    else if (w_shift) r_csum <= r_csum ^ in_data;
`else
  assign w_beat_next = w_next == S_LEN || w_next == S_PAYLOAD;
`endif
  prog_loader_beat_packer #(.BEAT_W(BEAT_W)) u_packer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_start),
    .i_shift (w_shift),
    .i_beat  (in_data),
    .o_word  (w_word),
    .o_full  (w_full)
  );
  always_comb begin
    w_next = r_state;
    if (w_start) w_next = S_LEN;
    else if (r_state == S_LEN && w_acc) w_next = (in_data == '0 || w_len_bad) ? S_DONE : S_PAYLOAD;
    else if (w_full) w_next = S_WRITE;
    else if (r_state == S_WRITE) w_next = w_last ? S_LAST : S_PAYLOAD;
`ifdef PROG_LOADER_CHECKSUM_EN
    else if (r_state == S_CSUM && w_acc) w_next = S_DONE;
`endif
  end
  // Handshake and status outputs are registered decodes of the next state.
  always_ff @(posedge clk)
    if (reset) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_we         <= 1'b0;
      r_cpu_hold   <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_word_count <= '0;
      r_len        <= '0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= w_beat_next;
      r_we       <= w_next == S_WRITE;
      r_cpu_hold <= w_next != S_IDLE && w_next != S_DONE;
      r_done     <= w_next == S_DONE;
      if (w_next == S_WRITE) begin
        r_addr <= r_word_count[ADDR_W-1:0];
        r_data <= w_word;
      end
      if (w_start) r_word_count <= '0;
      else if (r_state == S_WRITE) r_word_count <= r_word_count + (ADDR_W+1)'(1);
      if (r_state == S_LEN && w_acc) r_len <= in_data[ADDR_W:0];
      if (w_start) r_err <= 1'b0;
      else if (r_state == S_LEN && w_acc && w_len_bad) r_err <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      else if (r_state == S_CSUM && w_acc && in_data != r_csum) r_err <= 1'b1;
`endif
    end
  assign in_ready   = r_in_ready;
  assign we_b       = r_we;
  assign cpu_hold   = r_cpu_hold;
  assign done       = r_done;
  assign err        = r_err;
  assign addr_b     = r_addr;
  assign data_b     = r_data;
  assign word_count = r_word_count;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboarded bench for prog_loader; expected bram writes are queued by the
// stimulus and popped by a monitor whenever we_b is seen.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready, we_b, cpu_hold, done, err;
  logic [15:0] in_data;
  logic [9:0]  addr_b;
  logic [47:0] data_b;
  logic [10:0] word_count;
  logic [47:0] mem [0:1023];
  logic [57:0] exp_q [$];
  int          n_chk = 0, n_pass = 0, n_writes = 0;
  logic        prev_done = 1'b0, prev_hold = 1'b0;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .addr_b(addr_b), .data_b(data_b), .we_b(we_b),
    .cpu_hold(cpu_hold), .done(done), .err(err), .word_count(word_count)
  );

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (we_b) begin
      chk("ready_low_in_write", in_ready, 0);
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", addr_b, data_b);
      end else chk("write", {addr_b, data_b}, exp_q.pop_front());
      mem[addr_b] = data_b;
      n_writes++;
    end
    if (done && !prev_done) begin
      chk("hold_at_done", cpu_hold, 0);
      chk("hold_before_done", prev_hold, 1);
    end
    prev_done = done;
    prev_hold = cpu_hold;
  end

  task automatic do_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input int gap);
    int t = 0;
    in_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL beat_timeout: in_ready low for 100 cycles on beat %0h", d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_csum(input logic [15:0] c);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(c, 0);
`else
    if (c === 16'hxxxx) $display("checksum beat skipped");
`endif
  endtask

  task automatic wait_done;
    int t = 0;
    @(negedge clk);
    while (!done && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("done_rises", done, 1);
  endtask

  task automatic load_basic(input int maxgap);
    logic [15:0] b [6];
    b = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    exp_q.push_back({10'd0, 48'h111122223333});
    exp_q.push_back({10'd1, 48'h444455556666});
    do_start;
    send(16'd2, $urandom_range(0, maxgap));
    for (int i = 0; i < 6; i++) send(b[i], $urandom_range(0, maxgap));
    send_csum(16'h7777);
    wait_done;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {in_ready, we_b, cpu_hold, done, err, addr_b, data_b, word_count}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    w0 = n_writes;
    load_basic(0);
    chk("basic_word_count", word_count, 2);
    chk("basic_err", err, 0);
    chk("basic_writes", n_writes - w0, 2);
    mem[0] = '0; mem[1] = '0;
    w0 = n_writes;
    load_basic(3);
    chk("gap_word_count", word_count, 2);
    chk("gap_writes", n_writes - w0, 2);
    chk("gap_mem0", mem[0], 48'h111122223333);
    chk("gap_mem1", mem[1], 48'h444455556666);
    w0 = n_writes;
    do_start;
    @(negedge clk);
    chk("start_clears_done", done, 0);
    chk("hold_in_len", cpu_hold, 1);
    send(16'd0, 0);
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_err", err, 0);
    chk("zero_word_count", word_count, 0);
    repeat (3) @(negedge clk);
    chk("zero_writes", n_writes - w0, 0);
    w0 = n_writes;
    do_start;
    send(16'd1025, 0);
    @(negedge clk);
    chk("oversize_err", err, 1);
    chk("oversize_done", done, 1);
    repeat (3) @(negedge clk);
    chk("oversize_writes", n_writes - w0, 0);
    do_start;
    @(negedge clk);
    chk("start_clears_err", err, 0);
    send(16'd1024, 0);
    @(negedge clk);
    chk("max_len_accepted", {in_ready, done, err, cpu_hold}, 4'b1001);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_from_payload", {in_ready, we_b, cpu_hold, done, err, word_count}, 0);
    reset = 1'b0;
    mem[0] = '0;
    exp_q.push_back({10'd0, 48'h111122223333});
    do_start;
    send(16'd2, 0);
    send(16'h1111, 0); send(16'h2222, 0); send(16'h3333, 0); send(16'h4444, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_mid_load", {in_ready, we_b, cpu_hold, done, err, addr_b, data_b, word_count}, 0);
    reset = 1'b0;
    chk("mem0_kept", mem[0], 48'h111122223333);
    mem[1] = '0;
    load_basic(1);
    chk("reload_word_count", word_count, 2);
    chk("reload_mem1", mem[1], 48'h444455556666);
`ifdef PROG_LOADER_CHECKSUM_EN
    exp_q.push_back({10'd0, 48'h000100020004});
    do_start;
    send(16'd1, 0); send(16'h0001, 0); send(16'h0002, 0); send(16'h0004, 0); send(16'h0007, 0);
    wait_done;
    chk("csum_good_err", err, 0);
    exp_q.push_back({10'd0, 48'h000100020004});
    do_start;
    send(16'd1, 0); send(16'h0001, 0); send(16'h0002, 0); send(16'h0004, 0); send(16'h0000, 0);
    wait_done;
    chk("csum_bad_err", err, 1);
`endif
    chk("exp_queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction-memory interface. The decoder FSM reads 48-bit instruction words from bram port A; this block writes them through bram port B.
- Accepts a 16-bit valid/ready beat stream (length header, then payload), packs every three beats into one 48-bit word, and writes consecutive words from address 0.
- Holds the CPU (cpu_hold) while a load is in progress.

Parameters:
- ADDR_W, 10, bram address width.
- BEAT_W, 16, stream beat width.
- WORD_W, 48, instruction word width; must equal 3*BEAT_W.
- MAX_WORDS, 1024, largest accepted length; must be at most 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; sampled only in IDLE or DONE.
- in_data  input  BEAT_W  stream beat.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a beat this cycle.
- addr_b  output  ADDR_W  bram port B address.
- data_b  output  WORD_W  bram port B write data.
- we_b  output  1  bram port B write enable; one-cycle pulse.
- cpu_hold  output  1  high from start acceptance until the load ends.
- done  output  1  load finished; level, held until the next start or reset.
- err  output  1  length or checksum error; level, cleared by start or reset.
- word_count  output  ADDR_W+1  number of words written so far.

Behaviour:
- Reset: state IDLE; all outputs 0 (in_ready, we_b, cpu_hold, done, err, addr_b, data_b, word_count). Reset is checked before any other action.
- Beat transfer: a beat moves only on a cycle where in_valid and in_ready are both high. in_ready is a registered decode of the state. It is high only in LEN and PAYLOAD, and never in the same cycle as we_b.
- States:
  - IDLE: on start, go to LEN; cpu_hold=1, done=0, err=0, word_count=0, beat counter=0.
  - LEN: the accepted beat is the length L (unsigned).
    - L=0: go to DONE.
    - L>MAX_WORDS: err=1, go to DONE.
    - Otherwise latch L, go to PAYLOAD.
  - PAYLOAD: beats fill the word MSB-first (beat0 -> [47:32], beat1 -> [31:16], beat2 -> [15:0]). Beat counter runs 0,1,2. On the third accepted beat, go to WRITE.
  - WRITE: exactly one cycle. we_b=1, addr_b=word_count[ADDR_W-1:0], data_b=packed word, in_ready=0. Next cycle word_count increments and beat counter returns to 0.
    - word_count+1==L: go to DONE (or CSUM when CHECKSUM_EN is defined).
    - Otherwise go to PAYLOAD.
  - DONE: done=1, cpu_hold=0, in_ready=0. A new start re-enters LEN and clears done and err.
- Latency: third payload beat accepted in cycle N -> we_b high in cycle N+1. Minimum 4 cycles per word.
- Stalls: in_valid low in any beat state holds the state and beat counter indefinitely; there is no timeout.
- Ignored inputs: start while in LEN, PAYLOAD, WRITE or CSUM is ignored. Beats presented in IDLE or DONE are not consumed.
- Address wrap: cannot occur, because L<=MAX_WORDS<=2**ADDR_W. word_count is ADDR_W+1 bits so it can hold 1024.
- Reset mid-load: return to IDLE immediately. Words already written stay in bram, with no rollback. we_b is 0 in the reset cycle.
- we_b is never asserted outside WRITE. data_b holds its last value when we_b=0.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - An extra state, CSUM, follows the last WRITE and accepts one beat.
  - Expected value: the 16-bit XOR of every payload beat (the length beat is excluded).
  - Mismatch sets err=1. Match or mismatch, go to DONE.
  - For L=0 no checksum beat is expected.
- Undefined: no CSUM state and no XOR register. err is raised only by a length error.

Decomposition:
- Shared package prog_loader_pkg holds:
  - state enum: IDLE, LEN, PAYLOAD, WRITE, DONE, and CSUM (CSUM only when the macro is defined);
  - BEATS_PER_WORD=3;
  - the default ADDR_W/WORD_W shared with bram.
- One natural sub-module, beat_packer: a 3-beat shift register with its counter, producing the packed word and a word_full flag.

Test Plan:
- Basic load: start, L=2, beats 0x1111,0x2222,0x3333,0x4444,0x5555,0x6666 -> we_b at addr 0 data 0x111122223333, then at addr 1 data 0x444455556666. done=1, word_count=2, cpu_hold falls the same cycle done rises.
- Backpressure and gaps: random in_valid gaps -> same bram contents as the basic load. in_ready=0 in every WRITE cycle, and no beat is lost or duplicated.
- Zero length: L=0 -> done=1 two cycles after start, no we_b ever, err=0.
- Oversize: L=1025 with MAX_WORDS=1024 -> err=1, done=1, no we_b.
- Reset mid-load: reset after the 4th payload beat -> all outputs 0 the next cycle. Word 0 remains in bram. A new load from start works correctly.
- With PROG_LOADER_CHECKSUM_EN: L=1, beats 0x0001,0x0002,0x0004, checksum 0x0007 -> err=0. Same load with checksum 0x0000 -> err=1. done=1 in both cases.
